// File: rtl/packed_slot_pkg.sv
// Shared types for the packed slot arbiter: slot payload layout and FSM states.
package packed_slot_pkg;

    localparam int unsigned SLOT_DW = 8;

    typedef struct packed {
        logic               valid;
        logic [SLOT_DW-1:0] data;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/packed_slot_arbiter_rr_pick.sv
// Combinational round-robin search: first requester at or after ptr (mod NREQ) wins.
module rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         win_oh,
    output logic [$clog2(NREQ)-1:0] win_idx,
    output logic                    any
);

    localparam int unsigned PW = $clog2(NREQ);

    int unsigned     k;
    logic [PW-1:0]   kk;

    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        k       = 0;
        kk      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k  = (32'(ptr) + i) % NREQ;
            kk = PW'(k);
            if (!any && req[kk]) begin
                any        = 1'b1;
                win_idx    = kk;
                win_oh[kk] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/packed_slot_arbiter.sv
// Round-robin, lockable arbiter granting NREQ requesters write access to a packed slot array.
module packed_slot_arbiter
    import packed_slot_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned DW      = SLOT_DW,
    parameter int unsigned MAXLOCK = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NREQ-1:0]                      req,
    input  logic [NREQ-1:0]                      lock,
    input  logic [NREQ-1:0][$clog2(DEPTH)-1:0]   wr_idx,
    input  logic [NREQ-1:0][DW-1:0]              wr_data,
    input  logic [DEPTH-1:0]                     clr,
    output logic [NREQ-1:0]                      gnt,
    output logic                                 busy,
    output logic [DEPTH-1:0][DW:0]               slots
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(MAXLOCK + 1);

    state_t                  state_q, state_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [PW-1:0]           owner_q, owner_d;
    logic [CW-1:0]           lock_cnt_q, lock_cnt_d;
    logic [NREQ-1:0]         gnt_q, gnt_d;
    logic                    busy_q;
    logic [DEPTH-1:0][DW:0]  slot_q, slot_d;
    logic                    wr_en;
    logic                    rel;

    logic [NREQ-1:0]         pick_oh;
    logic [PW-1:0]           pick_idx;
    logic                    pick_any;

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    // Next-state: decide write/hold/release for the current owner, then re-arbitrate on release.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        gnt_d      = gnt_q;
        wr_en      = 1'b0;
        rel        = 1'b0;

        case (state_q)
            IDLE: rel = 1'b1;
            GRANT: begin
                if (req[owner_q]) begin
                    wr_en = 1'b1;
                    if (lock[owner_q]) begin
                        state_d    = LOCKED;
                        lock_cnt_d = CW'(1);
                    end else begin
                        rel = 1'b1;
                    end
                end else begin
                    rel = 1'b1;
                end
            end
            LOCKED: begin
                if (req[owner_q]) begin
                    wr_en = 1'b1;
                    // This cycle is granted cycle lock_cnt_q+1; release once it reaches MAXLOCK.
                    if (lock[owner_q] && (32'(lock_cnt_q) + 1 < MAXLOCK)) begin
                        lock_cnt_d = lock_cnt_q + CW'(1);
                    end else begin
                        rel = 1'b1;
                    end
                end else begin
                    rel = 1'b1;
                end
            end
            default: rel = 1'b1;
        endcase

        if (rel) begin
            lock_cnt_d = '0;
            if (pick_any) begin
                state_d = GRANT;
                gnt_d   = pick_oh;
                owner_d = pick_idx;
                ptr_d   = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        end
    end

    // Slot update: clear drops valid, a same-cycle write to that slot overrides it.
    always_comb begin
        slot_d = slot_q;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (clr[j]) slot_d[j][DW] = 1'b0;
        end
        if (wr_en) slot_d[wr_idx[owner_q]] = {1'b1, wr_data[owner_q]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            slot_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            gnt_q      <= gnt_d;
            busy_q     <= (state_d != IDLE);
            slot_q     <= slot_d;
        end
    end

    assign gnt   = gnt_q;
    assign busy  = busy_q;
    assign slots = slot_q;

endmodule
